uart_frame_parser: RTL and testbench
====================================

UART_FRAME_PARSER -- requirements
Module: uart_frame_parser

Interface
REQ-001 SHALL have parameter SOF, default 8'hA5, meaning start-of-frame byte.
REQ-002 SHALL have parameter TIMEOUT, default 50000, meaning the maximum idle clk cycles allowed between bytes inside a frame.
REQ-003 SHALL have port clk, input, width 1: the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, width 1: reset, synchronous and active-high.
REQ-005 SHALL have port in_data, input, width 8: byte from the upstream receive buffer.
REQ-006 SHALL have port in_valid, input, width 1: in_data is valid.
REQ-007 SHALL have port in_ready, output, width 1: the byte is accepted on a cycle where in_valid and in_ready are both high.
REQ-008 SHALL have port out_data, output, width 8: payload byte to the downstream transmitter.
REQ-009 SHALL have ports out_valid (output, width 1), out_ready (input, width 1) and out_last (output, width 1).
- out_valid/out_ready form the handshake.
- out_last marks the final payload byte of a frame.
REQ-010 SHALL have ports frame_ok and frame_err, output, width 1 each: single-cycle status pulses.
REQ-011 SHALL have ports ok_count and err_count, output, width 16 each: event counters.
REQ-012 SHALL have port state_dbg, output, width 2: current FSM state encoding.

Function
REQ-013 SHALL parse frames of the form SOF, LEN, LEN payload bytes, CHK.
- CHK is the 8-bit sum, mod 256, of LEN and all payload bytes.
REQ-014 SHALL implement FSM states IDLE=0, LEN=1, PAYLOAD=2, CHK=3.
REQ-015 In IDLE, SHALL assert in_ready and discard every byte other than SOF; an accepted SOF moves to LEN.
REQ-016 In LEN, SHALL handle an accepted byte as follows:
- 0: pulse frame_err and return to IDLE.
- Otherwise: load the remaining count and the running sum with that byte, then move to PAYLOAD.
REQ-017 In PAYLOAD, in_ready SHALL equal (~out_valid | out_ready).
- Each accepted byte loads out_data, sets out_valid the next cycle, adds to the sum and decrements the remaining count.
- out_last is set on the byte that brings the count to 0, and the FSM moves to CHK.
REQ-018 out_valid, out_data and out_last SHALL hold stable while out_valid=1 and out_ready=0.
- out_valid clears the cycle after a handshake unless a new byte was accepted on that same cycle.
REQ-019 In CHK, an accepted byte SHALL be compared with the sum, then the FSM returns to IDLE.
- Match: pulse frame_ok and increment ok_count.
- Mismatch: pulse frame_err and increment err_count.
REQ-020 Every frame_err pulse SHALL increment err_count; both counters wrap modulo 2^16.
REQ-021 Payload latency SHALL be exactly 1 cycle from input acceptance to out_valid.
REQ-022 A timeout counter SHALL run in states LEN, PAYLOAD and CHK.
- It is cleared on every accepted byte.
- When it reaches TIMEOUT: pulse frame_err and return to IDLE.
- A byte already held in the output register is still delivered, and out_last is not forced.
REQ-023 A timeout stall caused by out_ready=0 SHALL NOT count; the counter increments only while in_valid=0.
REQ-024 An SOF byte inside PAYLOAD or CHK SHALL be treated as data; no resynchronisation occurs.
REQ-025 In IDLE, in_ready SHALL be 1 regardless of out_ready, so garbage never stalls upstream.
REQ-026 frame_ok and frame_err SHALL never be asserted in the same cycle.

Reset
REQ-027 On rst=1, the FSM SHALL go to IDLE, a mid-frame reset aborts silently with no frame_err pulse, and outputs SHALL take these values:
- out_valid=0, out_data=0, out_last=0
- frame_ok=0, frame_err=0
- ok_count=0, err_count=0
- timeout counter=0
- in_ready=0 during reset, then 1 from the first cycle after reset.

Structure
REQ-028 A shared package uart_pkg SHALL hold the state enum (parser_state_t) and the SOF_DEFAULT constant.
REQ-029 The timeout counter SHALL be a sub-module, idle_timer, with ports clk, rst, clear, run and expired.
REQ-030 The implementation SHALL contain no combinational path from in_valid to out_valid.

Verification
REQ-031 Scenario: A5 03 01 02 03 09 with out_ready=1 -> out_data 01,02,03, out_last on 03, one frame_ok pulse, ok_count=1.
REQ-032 Scenario: A5 02 10 20 00 -> payload 10,20 is emitted, then frame_err, err_count=1, ok_count=0.
REQ-033 Scenario: 00 FF A5 00 -> the junk is dropped, frame_err on LEN=0, then IDLE.
REQ-034 Scenario: A5 02 11 with in_valid low for TIMEOUT cycles -> 11 is delivered, frame_err, IDLE; the next good frame is parsed correctly.
REQ-035 Scenario: out_ready low for 20 cycles mid-payload -> in_ready=0 and out_data stable, no timeout fires, and the frame still ends with frame_ok.
REQ-036 Scenario: rst asserted in PAYLOAD -> next cycle state_dbg=0, out_valid=0 and counters 0, with no frame_err pulse.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART frame parser.
package uart_pkg;

    localparam logic [7:0] SOF_DEFAULT = 8'hA5;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LEN     = 2'd1,
        ST_PAYLOAD = 2'd2,
        ST_CHK     = 2'd3
    } parser_state_t;

endpackage

// File: rtl/idle_timer.sv
// Inter-byte idle timer: counts run cycles since the last clear and
// saturates at LIMIT, holding expired high until cleared.
module idle_timer #(
    parameter int LIMIT = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic run,
    output logic expired
);

    localparam int W = (LIMIT < 2) ? 1 : $clog2(LIMIT + 1);

    logic [W-1:0] cnt_q, cnt_d;

    assign expired = (cnt_q == W'(LIMIT));

    // Next count: clear wins, otherwise count while running until saturated.
    always_comb begin
        cnt_d = cnt_q;
        if (clear)
            cnt_d = '0;
        else if (run && !expired)
            cnt_d = cnt_q + 1'b1;
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

endmodule

// File: rtl/uart_frame_parser.sv
// Frame parser: SOF, LEN, LEN payload bytes, CHK (8-bit sum of LEN+payload).
// Payload is forwarded through a single output register (1-cycle latency);
// frame status is reported as registered single-cycle pulses plus counters.
module uart_frame_parser
    import uart_pkg::*;
#(
    parameter logic [7:0] SOF     = SOF_DEFAULT,
    parameter int         TIMEOUT = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_last,
    output logic        frame_ok,
    output logic        frame_err,
    output logic [15:0] ok_count,
    output logic [15:0] err_count,
    output logic [1:0]  state_dbg
);

    parser_state_t state_q, state_d;
    logic [7:0]    rem_q, rem_d;
    logic [7:0]    sum_q, sum_d;
    logic [7:0]    out_data_q, out_data_d;
    logic          out_valid_q, out_valid_d;
    logic          out_last_q, out_last_d;
    logic          ok_q, ok_d;
    logic          err_q, err_d;
    logic [15:0]   ok_cnt_q, ok_cnt_d;
    logic [15:0]   err_cnt_q, err_cnt_d;

    logic rdy;
    logic in_fire;
    logic tmo_expired;

    // Idle timer only advances while upstream has nothing to offer, so an
    // output-side stall never counts as inactivity.
    idle_timer #(.LIMIT(TIMEOUT)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (in_fire | (state_q == ST_IDLE)),
        .run     ((state_q != ST_IDLE) & ~in_valid),
        .expired (tmo_expired)
    );

    // Upstream ready: always open in IDLE; in PAYLOAD only when the output
    // register can take a byte; closed on the timeout cycle so no byte is lost.
    always_comb begin
        rdy = 1'b0;
        if (!rst) begin
            case (state_q)
                ST_IDLE:    rdy = 1'b1;
                ST_PAYLOAD: rdy = (~out_valid_q | out_ready) & ~tmo_expired;
                default:    rdy = ~tmo_expired;
            endcase
        end
    end

    assign in_fire = in_valid & rdy;

    // Next-state, datapath and status logic.
    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        sum_d       = sum_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        ok_d        = 1'b0;
        err_d       = 1'b0;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (in_fire && in_data == SOF)
                    state_d = ST_LEN;
            end
            ST_LEN: begin
                if (tmo_expired) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else if (in_fire) begin
                    if (in_data == 8'd0) begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        rem_d   = in_data;
                        sum_d   = in_data;
                        state_d = ST_PAYLOAD;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (tmo_expired) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else if (in_fire) begin
                    out_data_d  = in_data;
                    out_valid_d = 1'b1;
                    out_last_d  = (rem_q == 8'd1);
                    sum_d       = sum_q + in_data;
                    rem_d       = rem_q - 8'd1;
                    if (rem_q == 8'd1)
                        state_d = ST_CHK;
                end
            end
            ST_CHK: begin
                if (tmo_expired) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else if (in_fire) begin
                    if (in_data == sum_q)
                        ok_d = 1'b1;
                    else
                        err_d = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        ok_cnt_d  = ok_d  ? ok_cnt_q  + 16'd1 : ok_cnt_q;
        err_cnt_d = err_d ? err_cnt_q + 16'd1 : err_cnt_q;
    end

    // State and output registers; reset aborts any frame silently.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            rem_q       <= '0;
            sum_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            ok_q        <= 1'b0;
            err_q       <= 1'b0;
            ok_cnt_q    <= '0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            sum_q       <= sum_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            ok_q        <= ok_d;
            err_q       <= err_d;
            ok_cnt_q    <= ok_cnt_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign in_ready  = rdy;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign frame_ok  = ok_q;
    assign frame_err = err_q;
    assign ok_count  = ok_cnt_q;
    assign err_count = err_cnt_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_uart_frame_parser.sv
// Bench for uart_frame_parser: frame table with payload scoreboard, plus
// directed sequences for latency, timeout, output stall and mid-frame reset.
module tb_uart_frame_parser;

    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  out_data;
    logic        out_valid;
    wire         out_ready;
    logic        out_last;
    logic        frame_ok;
    logic        frame_err;
    logic [15:0] ok_count;
    logic [15:0] err_count;
    logic [1:0]  state_dbg;

    logic stall   = 1'b0;
    logic rnd_rdy = 1'b0;
    logic rnd_bit = 1'b1;

    assign out_ready = stall ? 1'b0 : (rnd_rdy ? rnd_bit : 1'b1);

    always #5 clk = ~clk;

    uart_frame_parser #(.SOF(8'hA5), .TIMEOUT(TMO)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .frame_ok  (frame_ok),
        .frame_err (frame_err),
        .ok_count  (ok_count),
        .err_count (err_count),
        .state_dbg (state_dbg)
    );

    int checks = 0;
    int fails  = 0;
    int ok_seen = 0;
    int err_seen = 0;
    int exp_ok = 0;
    int exp_err = 0;

    logic [8:0] sbq[$];   // {last, data}

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Random downstream back-pressure, updated just after each edge.
    always @(posedge clk) begin
        #1;
        rnd_bit = ($urandom_range(0, 3) != 0);
    end

    // Output monitor: scoreboard pops, hold stability, status pulse tally.
    logic       hold = 1'b0;
    logic [8:0] hold_val = 9'h0;
    always @(negedge clk) begin
        if (!rst) begin
            if (hold) begin
                chk("hold_valid", 32'(out_valid), 32'd1);
                chk("hold_data", 32'({out_last, out_data}), 32'(hold_val));
            end
            if (out_valid && out_ready) begin
                if (sbq.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL unexpected_out: got %0h with empty scoreboard", {out_last, out_data});
                end else begin
                    chk("out_byte", 32'({out_last, out_data}), 32'(sbq.pop_front()));
                end
            end
            if (frame_ok)  ok_seen++;
            if (frame_err) err_seen++;
            if (frame_ok || frame_err)
                chk("ok_err_exclusive", 32'(frame_ok & frame_err), 32'd0);
            hold     = out_valid && !out_ready;
            hold_val = {out_last, out_data};
        end else begin
            hold = 1'b0;
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        int   t = 0;
        logic hs = 1'b0;
        in_data  = b;
        in_valid = 1'b1;
        while (!hs && t < 200) begin
            @(negedge clk);
            hs = in_ready;
            @(posedge clk);
            #1;
            t++;
        end
        if (!hs) begin
            checks++;
            fails++;
            $display("FAIL send_accept: byte %0h not accepted within 200 cycles", b);
        end
        in_valid = 1'b0;
        if (gap > 0) begin
            repeat (gap) @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_drain();
        int t = 0;
        while (sbq.size() != 0 && t < 500) begin
            @(posedge clk);
            t++;
        end
        if (sbq.size() != 0) begin
            checks++;
            fails++;
            $display("FAIL drain: %0d payload bytes never delivered", sbq.size());
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic check_status(input string tag);
        chk({tag, "_ok_pulses"}, 32'(ok_seen), 32'(exp_ok));
        chk({tag, "_err_pulses"}, 32'(err_seen), 32'(exp_err));
        chk({tag, "_ok_count"}, 32'(ok_count), 32'(exp_ok));
        chk({tag, "_err_count"}, 32'(err_count), 32'(exp_err));
        chk({tag, "_state_idle"}, 32'(state_dbg), 32'd0);
    endtask

    typedef struct {
        logic [0:7][7:0] b;
        int              n;
        logic [0:5][7:0] pay;
        int              np;
        int              ok;
        int              err;
    } vec_t;

    vec_t tbl[6];

    task automatic run_frame(input vec_t v, input bit rgap);
        for (int k = 0; k < v.np; k++)
            sbq.push_back({(k == v.np - 1), v.pay[k]});
        for (int j = 0; j < v.n; j++)
            send_byte(v.b[j], rgap ? $urandom_range(0, 3) : 0);
        wait_drain();
        exp_ok  += v.ok;
        exp_err += v.err;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{b: {8'hA5, 8'h03, 8'h01, 8'h02, 8'h03, 8'h09, 8'h00, 8'h00}, n: 6,
                   pay: {8'h01, 8'h02, 8'h03, 8'h00, 8'h00, 8'h00}, np: 3, ok: 1, err: 0};
        tbl[1] = '{b: {8'hA5, 8'h02, 8'h10, 8'h20, 8'h00, 8'h00, 8'h00, 8'h00}, n: 5,
                   pay: {8'h10, 8'h20, 8'h00, 8'h00, 8'h00, 8'h00}, np: 2, ok: 0, err: 1};
        tbl[2] = '{b: {8'h00, 8'hFF, 8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, n: 4,
                   pay: {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, np: 0, ok: 0, err: 1};
        tbl[3] = '{b: {8'hA5, 8'h01, 8'hA5, 8'hA6, 8'h00, 8'h00, 8'h00, 8'h00}, n: 4,
                   pay: {8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, np: 1, ok: 1, err: 0};
        tbl[4] = '{b: {8'hA5, 8'h04, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00}, n: 7,
                   pay: {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00}, np: 4, ok: 1, err: 0};
        tbl[5] = '{b: {8'h12, 8'hA5, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, n: 5,
                   pay: {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, np: 1, ok: 0, err: 1};

        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("in_ready_in_reset", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_last", 32'(out_last), 32'd0);
        chk("rst_pulses", 32'({frame_ok, frame_err}), 32'd0);
        chk("rst_counts", 32'({ok_count, err_count}), 32'd0);
        chk("rst_state", 32'(state_dbg), 32'd0);
        @(posedge clk);
        #1;

        // One-cycle payload latency on a single-byte frame.
        sbq.push_back({1'b1, 8'h42});
        send_byte(8'hA5, 0);
        send_byte(8'h01, 0);
        send_byte(8'h42, 0);
        chk("lat_out_valid", 32'(out_valid), 32'd1);
        chk("lat_out_data", 32'(out_data), 32'h42);
        chk("lat_out_last", 32'(out_last), 32'd1);
        send_byte(8'h43, 0);
        wait_drain();
        exp_ok++;
        check_status("lat");

        // Table frames under random gaps and back-pressure.
        rnd_rdy = 1'b1;
        for (int i = 0; i < 6; i++) begin
            run_frame(tbl[i], 1'b1);
            check_status($sformatf("tbl%0d", i));
        end
        rnd_rdy = 1'b0;
        @(posedge clk);
        #1;

        // Timeout mid-payload: held byte still delivered, then frame_err.
        sbq.push_back({1'b0, 8'h11});
        send_byte(8'hA5, 0);
        send_byte(8'h02, 0);
        send_byte(8'h11, 0);
        repeat (TMO - 3) @(posedge clk);
        #1;
        chk("tmo_before_state", 32'(state_dbg), 32'd2);
        chk("tmo_before_err", 32'(err_seen), 32'(exp_err));
        repeat (6) @(posedge clk);
        #1;
        exp_err++;
        chk("tmo_sb_empty", 32'(sbq.size()), 32'd0);
        check_status("tmo");
        run_frame(tbl[0], 1'b0);
        check_status("tmo_next");

        // Output stall longer than TIMEOUT with upstream still offering.
        sbq.push_back({1'b0, 8'h01});
        sbq.push_back({1'b0, 8'h02});
        sbq.push_back({1'b1, 8'h03});
        send_byte(8'hA5, 0);
        send_byte(8'h03, 0);
        send_byte(8'h01, 0);
        stall    = 1'b1;
        in_data  = 8'h02;
        in_valid = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            chk("stall_in_ready", 32'(in_ready), 32'd0);
            chk("stall_out_data", 32'(out_data), 32'h01);
            chk("stall_state", 32'(state_dbg), 32'd2);
        end
        @(posedge clk);
        #1;
        stall = 1'b0;
        send_byte(8'h02, 0);
        send_byte(8'h03, 0);
        send_byte(8'h09, 0);
        wait_drain();
        exp_ok++;
        check_status("stall");

        // Reset in PAYLOAD aborts silently and clears counters.
        sbq.push_back({1'b0, 8'h01});
        send_byte(8'hA5, 0);
        send_byte(8'h03, 0);
        send_byte(8'h01, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("prerst_state", 32'(state_dbg), 32'd2);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_state", 32'(state_dbg), 32'd0);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_counts", 32'({ok_count, err_count}), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd0);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("midrst_no_err", 32'(err_seen), 32'(exp_err));
        ok_seen  = 0;
        err_seen = 0;
        exp_ok   = 0;
        exp_err  = 0;
        run_frame(tbl[0], 1'b0);
        check_status("postrst");

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
